// File: rtl/ab_cond_pkg.sv
// Shared constants for the A/B input conditioner: debounce FSM state codes and default debounce length.
package ab_cond_pkg;

  // State code bit1 is the clean level, so clean can be read straight from the state register.
  localparam logic [1:0] ST_LOW       = 2'b00;
  localparam logic [1:0] ST_RISE_PEND = 2'b01;
  localparam logic [1:0] ST_HIGH      = 2'b11;
  localparam logic [1:0] ST_FALL_PEND = 2'b10;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/ab_input_conditioner_if.sv
// Raw A/B pin levels in, debounced levels and edge/change strobes out.
interface ab_input_conditioner_if;
  logic a_raw;
  logic b_raw;
  logic a_clean;
  logic b_clean;
  logic a_rise;
  logic a_fall;
  logic b_rise;
  logic b_fall;
  logic ab_changed;

  modport master (
    output a_raw, b_raw,
    input  a_clean, b_clean, a_rise, a_fall, b_rise, b_fall, ab_changed
  );

  modport slave (
    input  a_raw, b_raw,
    output a_clean, b_clean, a_rise, a_fall, b_rise, b_fall, ab_changed
  );
endinterface

// File: rtl/ab_input_conditioner_debounce_channel.sv
// One channel: 2-flop synchroniser followed by a counter-based debounce FSM with registered edge pulses.
module debounce_channel
  import ab_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o,
  output logic change_d_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1_q;
  logic             s_q;
  logic [1:0]       st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Synchroniser stage: only s_q is ever used by the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s_q  <= 1'b0;
    end else begin
      s1_q <= raw_i;
      s_q  <= s1_q;
    end
  end

  // Any bounce back to the settled level restarts the count from zero.
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    case (st_q)
      ST_LOW: begin
        if (s_q) begin
          st_d  = ST_RISE_PEND;
          cnt_d = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      ST_RISE_PEND: begin
        if (!s_q) begin
          st_d  = ST_LOW;
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          st_d   = ST_HIGH;
          cnt_d  = '0;
          rise_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!s_q) begin
          st_d  = ST_FALL_PEND;
          cnt_d = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      ST_FALL_PEND: begin
        if (s_q) begin
          st_d  = ST_HIGH;
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          st_d   = ST_LOW;
          cnt_d  = '0;
          fall_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        st_d  = ST_LOW;
        cnt_d = '0;
      end
    endcase
  end

  // FSM stage: state, counter and edge pulses update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= ST_LOW;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign clean_o    = st_q[1];
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  assign change_d_o = rise_d | fall_d;

endmodule

// File: rtl/ab_input_conditioner.sv
// Two independent debounced channels for the A/B detector plus a combined change strobe.
module ab_input_conditioner
  import ab_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  ab_input_conditioner_if.slave       bus
);

  logic a_change_d;
  logic b_change_d;
  logic ab_changed_q, ab_changed_d;

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan_a (
    .clk        (clk),
    .rst        (rst),
    .raw_i      (bus.a_raw),
    .clean_o    (bus.a_clean),
    .rise_o     (bus.a_rise),
    .fall_o     (bus.a_fall),
    .change_d_o (a_change_d)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan_b (
    .clk        (clk),
    .rst        (rst),
    .raw_i      (bus.b_raw),
    .clean_o    (bus.b_clean),
    .rise_o     (bus.b_rise),
    .fall_o     (bus.b_fall),
    .change_d_o (b_change_d)
  );

  // Built from the channels' next-cycle pulses so it lands on the same edge as rise/fall.
  assign ab_changed_d = a_change_d | b_change_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ab_changed_q <= 1'b0;
    else     ab_changed_q <= ab_changed_d;
  end

  assign bus.ab_changed = ab_changed_q;

endmodule

// File: tb/tb_ab_input_conditioner.sv
// Directed bench for ab_input_conditioner at the default debounce length of 4.
module tb_ab_input_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  ab_input_conditioner_if bus ();

  ab_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Output vector: {a_clean, b_clean, a_rise, a_fall, b_rise, b_fall, ab_changed}
  function automatic logic [6:0] outs();
    return {bus.a_clean, bus.b_clean, bus.a_rise, bus.a_fall,
            bus.b_rise, bus.b_fall, bus.ab_changed};
  endfunction

  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = outs();
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_chk(input string tag, input logic [6:0] exp);
    tick();
    chk(tag, exp);
  endtask

  initial begin
    bus.a_raw = 1'b0;
    bus.b_raw = 1'b0;

    // 1: reset behaviour and idle hold
    tick();
    chk("rst_held", 7'b0000000);
    tick();
    rst = 1'b0;
    tick_chk("rst_first_cycle", 7'b0000000);
    for (int i = 0; i < 20; i++) tick_chk("idle_low", 7'b0000000);

    // 2: A rises, accepted on 6th edge
    bus.a_raw = 1'b1;
    for (int i = 1; i <= 5; i++) tick_chk("a_rise_wait", 7'b0000000);
    tick_chk("a_rise_edge6", 7'b1010001);
    tick_chk("a_rise_edge7", 7'b1000000);

    // async reset mid-cycle clears outputs without a clock edge
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", 7'b0000000);
    tick();
    tick();
    rst = 1'b0;
    tick_chk("post_rst_first", 7'b0000000);
    for (int i = 2; i <= 5; i++) tick_chk("post_rst_wait", 7'b0000000);
    tick_chk("post_rst_edge6", 7'b1010001);

    // A falls back low
    bus.a_raw = 1'b0;
    for (int i = 1; i <= 5; i++) tick_chk("a_fall_wait", 7'b1000000);
    tick_chk("a_fall_edge6", 7'b0001001);
    tick_chk("a_fall_edge7", 7'b0000000);

    // 3: bounce 1,0,1,1,0 then settle 1
    bus.a_raw = 1'b1; tick_chk("bounce", 7'b0000000);
    bus.a_raw = 1'b0; tick_chk("bounce", 7'b0000000);
    bus.a_raw = 1'b1; tick_chk("bounce", 7'b0000000);
    bus.a_raw = 1'b1; tick_chk("bounce", 7'b0000000);
    bus.a_raw = 1'b0; tick_chk("bounce", 7'b0000000);
    bus.a_raw = 1'b1;
    for (int i = 1; i <= 5; i++) tick_chk("settle_wait", 7'b0000000);
    tick_chk("settle_edge6", 7'b1010001);
    tick_chk("settle_edge7", 7'b1000000);

    // 4: both rise together from low
    bus.a_raw = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    tick_chk("a_low_again", 7'b0001001);
    bus.a_raw = 1'b1;
    bus.b_raw = 1'b1;
    for (int i = 1; i <= 5; i++) tick_chk("both_wait", 7'b0000000);
    tick_chk("both_edge6", 7'b1110101);
    tick_chk("both_edge7", 7'b1100000);

    // 5: B low glitch of 3 cycles is rejected, 4 cycles is accepted
    bus.b_raw = 1'b0;
    for (int i = 1; i <= 3; i++) tick_chk("b_glitch3", 7'b1100000);
    bus.b_raw = 1'b1;
    for (int i = 1; i <= 8; i++) tick_chk("b_glitch3_hold", 7'b1100000);
    bus.b_raw = 1'b0;
    for (int i = 1; i <= 5; i++) tick_chk("b_low4_wait", 7'b1100000);
    tick_chk("b_low4_edge6", 7'b1000011);
    tick_chk("b_low4_edge7", 7'b1000000);

    // 6: reset while B is in RISE_PEND with cnt=2
    bus.b_raw = 1'b1;
    for (int i = 1; i <= 4; i++) tick_chk("b_pend", 7'b1000000);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_in_pend", 7'b0000000);
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) tick_chk("pend_rst_wait", 7'b0000000);
    tick_chk("pend_rst_edge6", 7'b1110101);
    tick_chk("pend_rst_edge7", 7'b1100000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ab_input_conditioner.md
Name: ab_input_conditioner

Overview:
- Front-end stage feeding the two-input Mealy detector that consumes A and B every clock.
- Takes raw asynchronous switch/pin levels a_raw and b_raw, synchronises each with a 2-flop synchroniser, and debounces it with a per-channel counter FSM.
- Presents glitch-free a_clean/b_clean levels plus single-cycle edge and change strobes, so the downstream FSM only ever sees stable, clock-aligned inputs.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronised cycles at the new level required to accept a change; legal range 2..65535.
- CNT_W, $clog2(DEBOUNCE_CYCLES)+1, debounce counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- a_raw  input  1  raw A level, asynchronous to clk.
- b_raw  input  1  raw B level, asynchronous to clk.
- a_clean  output  1  debounced A; drives the detector's A input.
- b_clean  output  1  debounced B; drives the detector's B input.
- a_rise  output  1  one-cycle pulse when a_clean goes 0->1.
- a_fall  output  1  one-cycle pulse when a_clean goes 1->0.
- b_rise  output  1  one-cycle pulse when b_clean goes 0->1.
- b_fall  output  1  one-cycle pulse when b_clean goes 1->0.
- ab_changed  output  1  one-cycle pulse when {b_clean,a_clean} differs from its previous value.

Behaviour:
Reset (rst=1, asynchronous, any time including mid-debounce):
- Clears sync flops, counters and both FSMs to LOW.
- All outputs 0 while rst is high and in the first cycle after release.

Synchroniser, per channel:
- s1 <= raw; s <= s1.
- s is the only signal the FSM samples.

Per-channel FSM: LOW, RISE_PEND, HIGH, FALL_PEND. Counter cnt is CNT_W bits.
- LOW: s=1 -> RISE_PEND, cnt=1; else stay, cnt=0.
- RISE_PEND, s=0: back to LOW, cnt=0, no output change.
- RISE_PEND, s=1 and cnt==DEBOUNCE_CYCLES-1: -> HIGH, clean<=1, rise pulse.
- RISE_PEND, s=1 otherwise: cnt++.
- HIGH / FALL_PEND: mirror of LOW / RISE_PEND with polarity inverted, producing fall pulse and clean<=0.

Outputs and timing:
- clean is the registered FSM output (HIGH or FALL_PEND -> 1).
- Rise/fall pulses are registered and assert in the same cycle clean changes.
- Latency: a raw level held stable changes clean on the (DEBOUNCE_CYCLES+2)th rising edge after the raw transition, i.e. 6 edges at default (2 sync + N debounce).
- A glitch stable for fewer than DEBOUNCE_CYCLES synchronised cycles never reaches clean. The counter restarts from scratch on every bounce.
- Counter never exceeds DEBOUNCE_CYCLES-1, so no wrap.

ab_changed:
- Registered: ab_changed = (a_rise|a_fall|b_rise|b_fall).
- Simultaneous A and B changes give one pulse, not two.

Other rules:
- Channels are fully independent; no arbitration between them.
- a_clean and b_clean are guaranteed constant between pulses.

Decomposition:
- Shared package ab_cond_pkg:
  - 2-bit state encoding constants ST_LOW=00, ST_RISE_PEND=01, ST_HIGH=11, ST_FALL_PEND=10; bit1 equals the clean level.
  - Default DEBOUNCE_CYCLES constant.
- One sub-module, debounce_channel: synchroniser, counter, FSM and rise/fall outputs for one bit, parameterised by DEBOUNCE_CYCLES.
- Top instantiates two channels and adds the ab_changed register.

Test Plan:
1. Reset then hold raws 0 for 20 cycles -> all outputs 0; assert async rst mid-cycle -> outputs 0 immediately, without waiting for a clock edge.
2. a_raw 0->1 held (N=4) -> a_clean=1 and a_rise=1 on edge 6 after the transition; a_rise low on edge 7; ab_changed pulses on edge 6; b outputs unchanged.
3. a_raw bounces 1,0,1,1,0 (one cycle each), then settles 1 -> no a_rise during the bounce; a_clean rises exactly 6 edges after the final 0->1.
4. a_raw and b_raw rise in the same cycle -> a_rise and b_rise together, single ab_changed pulse, {b_clean,a_clean}=11.
5. b_clean high, b_raw low pulse of 3 synchronised cycles -> no b_fall and b_clean stays 1; then a 4-cycle low -> b_fall, b_clean=0.
6. Assert rst while a channel is in RISE_PEND with cnt=2; release and keep a_raw high -> full 6-edge latency from release, no early a_rise.
